systolic_tile_feeder: RTL and testbench

- Source end of the 8x8 systolic PE cluster interface: buffers one 8x8 activation tile A and one 8x8 weight tile B, then streams them diagonally skewed onto the cluster's activations/weights/done inputs.
- Generates the array enable and reports tile completion upstream.
- Sits between the attention datapath's tile loader and the PE cluster.

---
 rtl/systolic_tile_feeder_if.sv | 24 ++
 rtl/systolic_tile_feeder.sv | 109 ++++++++++
 tb/tb_systolic_tile_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_tile_feeder_if.sv
// systolic_tile_feeder_if: tile loader write port, stream control, and the cluster-side
// activations/weights/done/en bus of the tile feeder.
interface systolic_tile_feeder_if #(parameter int N = 8, parameter int DW = 16);
  logic wr_en;
  logic wr_sel;
  logic [$clog2(N)-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic start;
  logic busy;
  logic tile_done;
  logic wr_err;
  logic [N*DW-1:0] activations;
  logic [N*DW-1:0] weights;
  logic [N-1:0] done;
  logic en;
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input busy, tile_done, wr_err, activations, weights, done, en
  );
  modport slave (
    input wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, tile_done, wr_err, activations, weights, done, en
  );
endinterface

// File: rtl/systolic_tile_feeder.sv
// systolic_tile_feeder: buffers an NxN A and B tile and streams them diagonally skewed into the PE cluster.
// FEEDER_DOUBLE_BUF_EN: ping/pong banks, writes never rejected, start while busy queues the next tile.
module systolic_tile_feeder #(
  parameter int N = 8,
  parameter int DW = 16,
  parameter int DRAIN_CYCLES = 16
) (
  input logic clk,
  input logic rst_n,
  systolic_tile_feeder_if.slave f
);
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(2 * N);
  localparam int DCW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(2 * N - 1);
  localparam logic [DCW-1:0] LAST_D = DCW'(DRAIN_CYCLES - 1);
`ifdef FEEDER_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  logic [1:0] state, state_n;
  logic [CW-1:0] c, k;
  logic [DCW-1:0] d;
  logic rb, wb, go, last_drain, restart, wr_ok, err_n, strm;
  logic [DW-1:0] act_mem [NB][N][N];
  logic [DW-1:0] wt_mem [NB][N][N];
  logic [N*DW-1:0] act_n, wt_n, act_q, wt_q;
  logic [N-1:0] done_n, done_q;
  logic en_q, td_q, err_q;
  assign go = state == IDLE && f.start;
  assign last_drain = state == DRAIN && d == LAST_D;
  // c == LAST_C is the hold cycle of the final beat, so the array sees DRAIN_CYCLES more enabled cycles
  assign strm = state == STREAM && c != LAST_C;
  assign state_n = (go || restart) ? STREAM : last_drain ? IDLE :
                   (state == STREAM && c == LAST_C) ? DRAIN : state;
`ifdef FEEDER_DOUBLE_BUF_EN
  logic pend, pnd;
  assign pnd = pend || (f.start && state != IDLE);
  assign restart = last_drain && pnd;
  assign wb = ~rb;
  assign wr_ok = f.wr_en;
  assign err_n = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= 1'b0;
      rb <= 1'b0;
    end else begin
      pend <= pnd && !last_drain;
      rb <= rb ^ (go || restart);
    end
`else
  assign restart = 1'b0;
  assign rb = 1'b0;
  assign wb = 1'b0;
  assign wr_ok = f.wr_en && state == IDLE;
  assign err_n = f.wr_en && state != IDLE;
`endif
  always_ff @(posedge clk)
    if (wr_ok)
      for (int m = 0; m < N; m++)
        if (f.wr_sel) wt_mem[wb][f.wr_addr][m] <= f.wr_data[m*DW +: DW];
        else act_mem[wb][f.wr_addr][m] <= f.wr_data[m*DW +: DW];
  // lane i carries reduction index k = c - i for both A rows and B columns
  always_comb begin
    act_n = '0;
    wt_n = '0;
    done_n = '0;
    k = '0;
    for (int i = 0; i < N; i++) begin
      k = c - CW'(i);
      if (strm && c >= CW'(i) && k < CW'(N)) begin
        act_n[i*DW +: DW] = act_mem[rb][i][k[AW-1:0]];
        wt_n[i*DW +: DW] = wt_mem[rb][k[AW-1:0]][i];
      end
      done_n[i] = strm && c == CW'(N - 1 + i);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      c <= '0;
      d <= '0;
      en_q <= 1'b0;
      td_q <= 1'b0;
      err_q <= 1'b0;
      act_q <= '0;
      wt_q <= '0;
      done_q <= '0;
    end else begin
      state <= state_n;
      c <= state == STREAM ? c + 1'b1 : '0;
      d <= state == DRAIN ? d + 1'b1 : '0;
      en_q <= state != IDLE && state_n != IDLE;
      td_q <= last_drain;
      err_q <= err_n;
      act_q <= act_n;
      wt_q <= wt_n;
      done_q <= done_n;
    end
  assign f.busy = state != IDLE;
  assign f.en = en_q;
  assign f.tile_done = td_q;
  assign f.wr_err = err_q;
  assign f.activations = act_q;
  assign f.weights = wt_q;
  assign f.done = done_q;
endmodule

// File: tb/tb_systolic_tile_feeder.sv
// tb_systolic_tile_feeder: scoreboard bench for the skewed tile stream, timing, write rejection and reset.
module tb_systolic_tile_feeder;
  localparam int N = 8, DW = 16;
  typedef struct packed {
    logic [N*DW-1:0] act;
    logic [N*DW-1:0] wt;
    logic [N-1:0] done;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0;
  logic [DW-1:0] a_m [N][N];
  logic [DW-1:0] b_m [N][N];
  beat_t sb [$];
  always #5 clk = ~clk;
  systolic_tile_feeder_if #(.N(N), .DW(DW)) bus ();
  systolic_tile_feeder #(.N(N), .DW(DW), .DRAIN_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .f(bus));

  function automatic logic [N*DW-1:0] row_pat(input int base);
    logic [N*DW-1:0] r = '0;
    for (int m = 0; m < N; m++) r[m*DW +: DW] = DW'(base + m);
    return r;
  endfunction

  function automatic void set_model(input logic sel, input int addr, input logic [N*DW-1:0] data);
    for (int m = 0; m < N; m++)
      if (sel) b_m[addr][m] = data[m*DW +: DW];
      else a_m[addr][m] = data[m*DW +: DW];
  endfunction

  function automatic beat_t model_beat(input int c);
    beat_t b = '0;
    for (int i = 0; i < N; i++) begin
      if (c - i >= 0 && c - i < N) begin
        b.act[i*DW +: DW] = a_m[i][c-i];
        b.wt[i*DW +: DW] = b_m[c-i][i];
      end
      b.done[i] = c == N - 1 + i;
    end
    return b;
  endfunction

  function automatic beat_t sample();
    beat_t g;
    g.act = bus.activations;
    g.wt = bus.weights;
    g.done = bus.done;
    return g;
  endfunction

  task automatic write_row(input logic sel, input int addr, input logic [N*DW-1:0] data);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_sel = sel;
    bus.wr_addr = 3'(addr);
    bus.wr_data = data;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic load_tile(input int abase);
    for (int i = 0; i < N; i++) begin
      write_row(1'b0, i, row_pat(abase + 16 * i));
      set_model(1'b0, i, row_pat(abase + 16 * i));
    end
    for (int kk = 0; kk < N; kk++) begin
      write_row(1'b1, kk, row_pat(256 + 8 * kk));
      set_model(1'b1, kk, row_pat(256 + 8 * kk));
    end
  endtask

  task automatic pulse_start;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({bus.busy, bus.tile_done, bus.wr_err, bus.en, bus.done, bus.activations, bus.weights} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b td=%b err=%b en=%b done=%h required all 0",
               bus.busy, bus.tile_done, bus.wr_err, bus.en, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.en, bus.tile_done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b en=%b td=%b required 000", bus.busy, bus.en, bus.tile_done);
    end
  endtask

  task automatic run_tile(input string name, input int spot, input logic wr, input logic [N*DW-1:0] wdata);
    beat_t got, exp;
    int en_cnt = 0, td_at = -1;
    logic busy_td = 1'b1;
    if (wr) set_model(1'b0, 0, wdata);
    for (int c = 0; c < 2 * N - 1; c++) sb.push_back(model_beat(c));
    @(negedge clk);
    bus.start = 1'b1;
    if (wr) begin
      bus.wr_en = 1'b1;
      bus.wr_sel = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = wdata;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.en !== 1'b0) begin
      failures++;
      $display("FAIL %s_start got busy=%b en=%b required busy=1 en=0", name, bus.busy, bus.en);
    end
    for (int cyc = 1; cyc <= 40 && td_at < 0; cyc++) begin
      @(posedge clk);
      #1;
      got = sample();
      if (bus.en === 1'b1) en_cnt++;
      if (bus.tile_done === 1'b1) begin
        td_at = cyc;
        busy_td = bus.busy;
      end
      if (cyc <= 2 * N - 1 && sb.size() > 0) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s_beat%0d got act=%h wt=%h done=%h required act=%h wt=%h done=%h",
                   name, cyc - 1, got.act, got.wt, got.done, exp.act, exp.wt, exp.done);
        end
      end else if (cyc > 2 * N - 1) begin
        checks++;
        if (got !== '0) begin
          failures++;
          $display("FAIL %s_drain_zero cycle %0d got act=%h required 0", name, cyc, got.act);
        end
      end
      if (spot == 1 && cyc == 1) begin
        checks++;
        if (got.act !== '0 || got.wt[15:0] !== 16'h0100 || got.wt[N*DW-1:16] !== '0) begin
          failures++;
          $display("FAIL %s_spot_beat0 got act=%h wt=%h required act=0 wt lane0=0100 only", name, got.act, got.wt);
        end
      end
      if (spot == 1 && cyc == 8) begin
        checks++;
        if (got.act[127:112] !== 16'h0070 || got.act[15:0] !== 16'h0007 || got.done !== 8'b0000_0001) begin
          failures++;
          $display("FAIL %s_spot_beat7 got act7=%h act0=%h done=%b required 0070 0007 00000001",
                   name, got.act[127:112], got.act[15:0], got.done);
        end
      end
      if (spot == 1 && cyc == 15) begin
        checks++;
        if (got.act[127:112] !== 16'h0077 || got.wt[127:112] !== 16'h013F || got.done !== 8'b1000_0000) begin
          failures++;
          $display("FAIL %s_spot_beat14 got act7=%h wt7=%h done=%b required 0077 013F 10000000",
                   name, got.act[127:112], got.wt[127:112], got.done);
        end
      end
      if (spot == 2 && cyc == 1) begin
        checks++;
        if (got.act[15:0] !== 16'hAAAA) begin
          failures++;
          $display("FAIL %s_lane0 got %h required AAAA", name, got.act[15:0]);
        end
      end
    end
    checks++;
    if (td_at != 32) begin
      failures++;
      $display("FAIL %s_tile_done_cycle got %0d required 32", name, td_at);
    end
    checks++;
    if (en_cnt != 31) begin
      failures++;
      $display("FAIL %s_en_cycles got %0d required 31", name, en_cnt);
    end
    checks++;
    if (busy_td !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_at_done got %b required 0", name, busy_td);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.tile_done !== 1'b0 || bus.en !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_done got td=%b en=%b required 0 0", name, bus.tile_done, bus.en);
    end
    sb.delete();
  endtask

  task automatic test_stream;
    run_tile("stream", 1, 1'b0, '0);
  endtask

  task automatic test_wr_err;
    int seen = 0;
    pulse_start;
    repeat (3) @(posedge clk);
    write_row(1'b0, 3, {N{16'hBEEF}});
    checks++;
    if (bus.wr_err !== 1'b1) begin
      failures++;
      $display("FAIL wr_err_pulse got %b required 1", bus.wr_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wr_err !== 1'b0) begin
      failures++;
      $display("FAIL wr_err_single got %b required 0", bus.wr_err);
    end
    for (int cyc = 0; cyc < 60 && seen == 0; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.tile_done === 1'b1) seen = 1;
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("FAIL wr_err_tile_done got none required pulse within 60 cycles");
    end
    run_tile("old_row3", 0, 1'b0, '0);
  endtask

  task automatic test_reset_midstream;
    int td = 0;
    pulse_start;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bus.activations[5*DW +: DW] !== a_m[5][0]) begin
      failures++;
      $display("FAIL mid_beat5 got lane5=%h required %h", bus.activations[5*DW +: DW], a_m[5][0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.tile_done, bus.wr_err, bus.en, bus.done, bus.activations, bus.weights} !== '0) begin
      failures++;
      $display("FAIL async_reset got busy=%b en=%b done=%h act=%h required all 0",
               bus.busy, bus.en, bus.done, bus.activations);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.tile_done === 1'b1) td++;
    end
    checks++;
    if (td != 0) begin
      failures++;
      $display("FAIL abandoned_tile_done got %0d pulses required 0", td);
    end
    run_tile("replay", 1, 1'b0, '0);
  endtask

  task automatic test_same_edge;
    run_tile("same_edge", 2, 1'b1, {N{16'hAAAA}});
  endtask

`ifdef FEEDER_DOUBLE_BUF_EN
  task automatic test_double_buf;
    int td_at = -1, en_low = 0;
    beat_t exp;
    pulse_start;
    load_tile(16'h1000);
    pulse_start;
    for (int cyc = 18; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.en !== 1'b1) en_low++;
      if (td_at >= 0 && cyc == td_at + 1) begin
        exp = model_beat(0);
        checks++;
        if (sample() !== exp) begin
          failures++;
          $display("FAIL dbuf_beat0 got act=%h wt=%h required act=%h wt=%h", bus.activations, bus.weights, exp.act, exp.wt);
        end
        break;
      end
      if (td_at < 0 && bus.tile_done === 1'b1) td_at = cyc;
    end
    checks++;
    if (td_at != 32) begin
      failures++;
      $display("FAIL dbuf_tile_done got %0d required 32", td_at);
    end
    checks++;
    if (en_low != 0) begin
      failures++;
      $display("FAIL dbuf_en_gap got %0d low cycles required 0", en_low);
    end
    repeat (40) @(posedge clk);
  endtask
`endif

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_sel = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start = 1'b0;
    test_reset;
    load_tile(0);
    test_stream;
`ifdef FEEDER_DOUBLE_BUF_EN
    test_double_buf;
`else
    test_wr_err;
    test_reset_midstream;
    test_same_edge;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
